// File: rtl/kpn_sched_pkg.sv
// Shared constants and state encoding for the KPN multiplier scheduler.
package kpn_sched_pkg;

  localparam int unsigned NCH        = 2;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_RES_W  = 32;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_MUL     = 3'd3,
    S_WRITE   = 3'd4
  } state_e;

  function automatic logic [NCH-1:0] ch_onehot(input logic idx);
    ch_onehot = idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/kpn_rr_arbiter2.sv
// Two-way round-robin picker: the pointer only breaks ties when both channels are eligible.
module kpn_rr_arbiter2 (
  input  logic [1:0] eligible_i,
  input  logic       ptr_i,
  output logic       valid_o,
  output logic       grant_o
);

  always_comb begin
    valid_o = |eligible_i;
    grant_o = 1'b0;
    unique case (eligible_i)
      2'b01:   grant_o = 1'b0;
      2'b10:   grant_o = 1'b1;
      2'b11:   grant_o = ptr_i;
      default: grant_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/kpn_mult_scheduler.sv
// Shares one multiplier between two KPN channels: read operands, multiply, write product.
// Optional per-channel operation counters are enabled with KPN_SCHED_STATS_EN.
module kpn_mult_scheduler
  import kpn_sched_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned RES_W   = DEF_RES_W,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          ch_empty_1,
  input  logic [1:0]          ch_empty_2,
  input  logic [2*DATA_W-1:0] ch_din_1,
  input  logic [2*DATA_W-1:0] ch_din_2,
  output logic [1:0]          ch_rd,
  input  logic [1:0]          ch_full,
  output logic [1:0]          ch_wr,
  output logic [RES_W-1:0]    ch_dout,
  output logic [DATA_W-1:0]   mul_a,
  output logic [DATA_W-1:0]   mul_b,
  input  logic [RES_W-1:0]    mul_p,
  output logic                busy,
  output logic                grant
`ifdef KPN_SCHED_STATS_EN
  ,
  output logic [15:0]         ops_cnt_0,
  output logic [15:0]         ops_cnt_1
`endif
);

  state_e             state_q, state_d;
  logic               grant_q, grant_d;
  logic               ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  mul_a_q, mul_a_d;
  logic [DATA_W-1:0]  mul_b_q, mul_b_d;
  logic [RES_W-1:0]   dout_q, dout_d;

  logic [1:0]         eligible;
  logic               arb_valid;
  logic               arb_grant;

  assign eligible = ~ch_empty_1 & ~ch_empty_2 & ~ch_full;

  kpn_rr_arbiter2 u_arb (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .valid_o    (arb_valid),
    .grant_o    (arb_grant)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    dout_d  = dout_q;
    ch_rd   = 2'b00;
    ch_wr   = 2'b00;

    unique case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          grant_d = arb_grant;
          state_d = S_READ;
        end
      end
      S_READ: begin
        ch_rd   = ch_onehot(grant_q);
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // FIFO data appears the cycle after the read strobe.
        mul_a_d = grant_q ? ch_din_1[2*DATA_W-1:DATA_W] : ch_din_1[DATA_W-1:0];
        mul_b_d = grant_q ? ch_din_2[2*DATA_W-1:DATA_W] : ch_din_2[DATA_W-1:0];
        cnt_d   = CNT_W'(MUL_LAT);
        state_d = S_MUL;
      end
      S_MUL: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          dout_d  = mul_p;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!ch_full[grant_q]) begin
          ch_wr   = ch_onehot(grant_q);
          ptr_d   = ~grant_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= 1'b0;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      dout_q  <= dout_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign grant   = grant_q;
  assign mul_a   = mul_a_q;
  assign mul_b   = mul_b_q;
  assign ch_dout = dout_q;

`ifdef KPN_SCHED_STATS_EN
  logic [15:0] ops_cnt_0_q, ops_cnt_0_d;
  logic [15:0] ops_cnt_1_q, ops_cnt_1_d;

  always_comb begin
    ops_cnt_0_d = ops_cnt_0_q;
    ops_cnt_1_d = ops_cnt_1_q;
    if (ch_wr[0]) ops_cnt_0_d = ops_cnt_0_q + 16'd1;
    if (ch_wr[1]) ops_cnt_1_d = ops_cnt_1_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_cnt_0_q <= '0;
      ops_cnt_1_q <= '0;
    end else begin
      ops_cnt_0_q <= ops_cnt_0_d;
      ops_cnt_1_q <= ops_cnt_1_d;
    end
  end

  assign ops_cnt_0 = ops_cnt_0_q;
  assign ops_cnt_1 = ops_cnt_1_q;
`endif

endmodule
